// File: rtl/raifes_hasti_master.sv
// -----------------------------------------------------------------------------
// raifes_hasti_master
//
// Single-transfer HASTI (AHB-Lite) bus initiator. Each command accepted on the
// valid/ready interface becomes one NONSEQ/SINGLE transfer. Exactly one
// response pulse is returned per accepted command. Only one transfer is ever
// outstanding.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_write         1 = write, 0 = read
//   cmd_addr          byte address
//   cmd_size          0 = byte, 1 = half, 2 = word (3 is rejected)
//   cmd_wdata         right-aligned write data
//   rsp_valid         one-cycle response pulse
//   rsp_rdata         right-aligned, zero-extended read data (0 for writes)
//   rsp_err           bus error, misalignment or timeout
//   rsp_timeout       response was produced by the stall timeout
//   h*                AHB-Lite master signals
//
// Optional feature: define HASTI_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES consecutive hready-low cycles. Without it the master waits
// for hready indefinitely and rsp_timeout is always 0.
// -----------------------------------------------------------------------------
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module raifes_hasti_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic                           cmd_write,
   input  logic [`HASTI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [1:0]                     cmd_size,
   input  logic [`HASTI_BUS_WIDTH-1:0]    cmd_wdata,
   output logic                           rsp_valid,
   output logic [31:0]                    rsp_rdata,
   output logic                           rsp_err,
   output logic                           rsp_timeout,
   output logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
   output logic                           hwrite,
   output logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
   output logic [`HASTI_BURST_WIDTH-1:0]  hburst,
   output logic                           hmastlock,
   output logic [`HASTI_PROT_WIDTH-1:0]   hprot,
   output logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
   output logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
   input  logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
   input  logic                           hready,
   input  logic [`HASTI_RESP_WIDTH-1:0]   hresp
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t      state, state_next;
   logic [31:0] haddr_next, hwdata_next, rsp_rdata_next;
   logic [31:0] wdata_q, wdata_q_next;
   logic [2:0]  hsize_next;
   logic [1:0]  htrans_next;
   logic        hwrite_next, rsp_valid_next, rsp_err_next, rsp_timeout_next;
   logic        cmd_legal, timeout_hit;
   logic [31:0] wdata_rep, rdata_lane;

   assign hburst    = 3'b000;
   assign hmastlock = 1'b0;
   assign hprot     = HPROT_VAL;

   // Handshake is only offered while idle and never while reset is held.
   assign cmd_ready = (state == S_IDLE) && !reset;

   always_comb begin
      unique case (cmd_size)
         2'd0:    cmd_legal = 1'b1;
         2'd1:    cmd_legal = !cmd_addr[0];
         2'd2:    cmd_legal = (cmd_addr[1:0] == 2'b00);
         default: cmd_legal = 1'b0;
      endcase
   end

   // Replicate the right-aligned write data onto every lane it could occupy.
   always_comb begin
      unique case (hsize[1:0])
         2'd0:    wdata_rep = {4{wdata_q[7:0]}};
         2'd1:    wdata_rep = {2{wdata_q[15:0]}};
         default: wdata_rep = wdata_q;
      endcase
   end

   // Pick the addressed lane out of the read bus and right-align it.
   always_comb begin
      unique case (hsize[1:0])
         2'd0:    rdata_lane = {24'b0, hrdata[{haddr[1:0], 3'b000} +: 8]};
         2'd1:    rdata_lane = {16'b0, hrdata[{haddr[1], 4'b0000} +: 16]};
         default: rdata_lane = hrdata;
      endcase
   end

`ifdef HASTI_MASTER_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] stall_cnt;
   logic             in_bus_phase;

   assign in_bus_phase = (state == S_ADDR) || (state == S_DATA);

   // Counts stalls seen before the current cycle; the stall in the current
   // cycle is the one that reaches the limit.
   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (in_bus_phase && !hready)
         stall_cnt <= stall_cnt + 1'b1;
      else
         stall_cnt <= '0;
   end

   assign timeout_hit = in_bus_phase && !hready && (stall_cnt == CNT_LAST);
`else
   logic [31:0] timeout_cycles_unused;
   assign timeout_cycles_unused = TIMEOUT_CYCLES;
   assign timeout_hit           = 1'b0;
`endif

   // NOTE: every signal assigned here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next       = state;
      haddr_next       = haddr;
      hwrite_next      = hwrite;
      hsize_next       = hsize;
      htrans_next      = htrans;
      hwdata_next      = hwdata;
      wdata_q_next     = wdata_q;
      rsp_valid_next   = 1'b0;
      rsp_rdata_next   = rsp_rdata;
      rsp_err_next     = rsp_err;
      rsp_timeout_next = rsp_timeout;

      unique case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_legal) begin
                  haddr_next   = cmd_addr;
                  hwrite_next  = cmd_write;
                  hsize_next   = {1'b0, cmd_size};
                  htrans_next  = TRANS_NONSEQ;
                  wdata_q_next = cmd_wdata;
                  state_next   = S_ADDR;
               end else begin
                  // Rejected locally: nothing reaches the bus.
                  rsp_valid_next   = 1'b1;
                  rsp_err_next     = 1'b1;
                  rsp_timeout_next = 1'b0;
                  rsp_rdata_next   = '0;
                  state_next       = S_RESP;
               end
            end
         end
         S_ADDR: begin
            if (timeout_hit) begin
               htrans_next      = TRANS_IDLE;
               rsp_valid_next   = 1'b1;
               rsp_err_next     = 1'b1;
               rsp_timeout_next = 1'b1;
               rsp_rdata_next   = '0;
               state_next       = S_RESP;
            end else if (hready) begin
               htrans_next = TRANS_IDLE;
               if (hwrite)
                  hwdata_next = wdata_rep;
               state_next = S_DATA;
            end
         end
         S_DATA: begin
            // The first cycle of a two-cycle ERROR has hready low and is
            // simply waited out; hresp is sampled on the completing cycle.
            if (timeout_hit) begin
               rsp_valid_next   = 1'b1;
               rsp_err_next     = 1'b1;
               rsp_timeout_next = 1'b1;
               rsp_rdata_next   = '0;
               state_next       = S_RESP;
            end else if (hready) begin
               rsp_valid_next   = 1'b1;
               rsp_err_next     = hresp[0];
               rsp_timeout_next = 1'b0;
               rsp_rdata_next   = hwrite ? 32'b0 : rdata_lane;
               state_next       = S_RESP;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         haddr       <= '0;
         hwrite      <= 1'b0;
         hsize       <= '0;
         htrans      <= TRANS_IDLE;
         hwdata      <= '0;
         wdata_q     <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_next;
         haddr       <= haddr_next;
         hwrite      <= hwrite_next;
         hsize       <= hsize_next;
         htrans      <= htrans_next;
         hwdata      <= hwdata_next;
         wdata_q     <= wdata_q_next;
         rsp_valid   <= rsp_valid_next;
         rsp_rdata   <= rsp_rdata_next;
         rsp_err     <= rsp_err_next;
         rsp_timeout <= rsp_timeout_next;
      end
   end

endmodule

// File: doc/raifes_hasti_master.md
Name: raifes_hasti_master

Overview:
Single-transfer HASTI (AHB-Lite) bus initiator. It converts a simple valid/ready command interface into NONSEQ/SINGLE bus transfers and returns one response per command. It is the requester-side counterpart to the memory-mapped peripherals on the system bus (GPIO, imem/dmem), and serves as the bus master for debug/UART-to-bus bridges and for peripheral test benches.

Parameters:
TIMEOUT_CYCLES, 255, max consecutive hready-low cycles before abort (used only with the optional feature).
HPROT_VAL, 4'b0011, constant driven on hprot (data access, privileged).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  `HASTI_ADDR_WIDTH (32)  byte address
cmd_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
cmd_wdata  in  `HASTI_BUS_WIDTH (32)  write data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read data, zero-extended and right-aligned; 0 for writes
rsp_err  out  1  bus error, misalignment or timeout (valid with rsp_valid)
rsp_timeout  out  1  response caused by timeout
haddr  out  `HASTI_ADDR_WIDTH  bus address
hwrite  out  1  bus write
hsize  out  `HASTI_SIZE_WIDTH (3)  transfer size
hburst  out  `HASTI_BURST_WIDTH (3)  constant 3'b000 (SINGLE)
hmastlock  out  1  constant 0
hprot  out  `HASTI_PROT_WIDTH (4)  constant HPROT_VAL
htrans  out  `HASTI_TRANS_WIDTH (2)  IDLE = 2'b00, NONSEQ = 2'b10
hwdata  out  `HASTI_BUS_WIDTH  write data (data phase)
hrdata  in  `HASTI_BUS_WIDTH  read data
hready  in  1  slave ready
hresp  in  `HASTI_RESP_WIDTH (1)  0 = OKAY, 1 = ERROR

Behaviour:
- All bus and response outputs are registered.
- Reset values: htrans = IDLE, haddr = 0, hwrite = 0, hsize = 0, hwdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0, cmd_ready = 0 during reset.
- FSM states are IDLE, ADDR, DATA and RESP.
- IDLE: cmd_ready = 1.
  - On accept of an aligned, legal command: latch the command, drive haddr/hwrite/hsize = {0, cmd_size}/htrans = NONSEQ from the next cycle, and go to ADDR.
  - On accept of a misaligned command (half with addr[0] set; word with addr[1:0] nonzero) or cmd_size = 3: no bus transfer; go to RESP with rsp_err = 1.
- ADDR: hold haddr/hwrite/hsize/htrans stable while hready = 0. On hready = 1, go to DATA; in DATA htrans = IDLE and hwdata = lane-replicated write data.
- Write lane replication: byte writes drive {4{b}}, half writes drive {2{h}}, word writes drive w. hwdata is held stable for the whole data phase.
- DATA: wait for hready = 1. Then:
  - Capture hresp into rsp_err.
  - For reads, select the lane by the haddr low bits, zero-extend, and store in rsp_rdata.
  - Go to RESP.
  - ERROR responses, including the two-cycle ERROR signalling, complete on the hready = 1 cycle; the first ERROR cycle (hready = 0) is treated as a wait.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. cmd_ready = 0 in ADDR, DATA and RESP, so only one transfer is outstanding.
- Latency: a zero-wait-state slave gives accept at cycle N, NONSEQ at N+1, data phase at N+2, rsp_valid at N+3. Each hready-low cycle adds one cycle.
- Reset mid-transfer: return immediately to IDLE with htrans = IDLE. No response is issued for the aborted command.
- Without the timeout feature, the block waits indefinitely for hready.

Optional Feature:
Macro HASTI_MASTER_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (wide enough for TIMEOUT_CYCLES) counts consecutive hready = 0 cycles in ADDR or DATA and clears on every hready = 1.
  - When the count reaches TIMEOUT_CYCLES, drive htrans = IDLE and go to RESP with rsp_err = 1, rsp_timeout = 1 and rsp_rdata = 0.
- Not defined: no counter; rsp_timeout is tied to 0.

Test Plan:
- Zero-wait slave, word write addr 0xC0000000 data 0x000000A5 -> NONSEQ one cycle after accept, hwdata = 0x000000A5 in the next cycle, rsp_valid at N+3, rsp_err = 0.
- Byte read addr 0xC0000006, slave returns 0x11223344 with 2 wait states in data phase -> rsp_rdata = 0x00000022, rsp_valid at N+5.
- Byte write 0x5A to 0xC0000004 -> hsize = 0, hwdata = 0x5A5A5A5A held through wait states.
- Word read at 0x00000002 -> no htrans NONSEQ observed, rsp_valid at N+1 with rsp_err = 1.
- Slave gives two-cycle ERROR on a write -> rsp_err = 1, htrans IDLE during the error, block is back in IDLE accepting a new command.
- Slave holds hready = 0 forever with HASTI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16 -> after 16 stalled cycles rsp_valid with rsp_err = 1, rsp_timeout = 1. A reset asserted mid-stall instead yields no rsp_valid and htrans = IDLE.
